lane_result_collector: RTL

//  - Receive end of the packed nibble-lane result bus: LANES lanes x (LW+1) bits per word, lane 0 in the LSBs.
//  - Each lane field is {lane carry, LW-bit lane value}.
//  - Ripples carries lane by lane, one lane per clk, and rebuilds a LANES*LW-bit result word with a final carry.
//  - Uses valid/ready handshakes on both sides. Sits between the lane array output register and downstream consumers.

---
 rtl/lane_result_collector_if.sv | 28 ++
 rtl/lane_result_collector.sv | 135 +++++++++++++
 2 files changed

// File: rtl/lane_result_collector_if.sv
// Handshake bundle for lane_result_collector.
// The slave modport is the collector itself; master is the side that feeds
// packed lane words in and takes resolved words out.
interface lane_result_collector_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned LW    = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*(LW+1)-1:0] in_data;
  logic                    in_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*LW-1:0]     out_data;
  logic                    out_cay;
  logic                    out_err;
  logic [LANES*LW/8-1:0]   out_par;

  modport slave (
    input  in_valid, in_data, in_err, out_ready,
    output in_ready, out_valid, out_data, out_cay, out_err, out_par
  );

  modport master (
    output in_valid, in_data, in_err, out_ready,
    input  in_ready, out_valid, out_data, out_cay, out_err, out_par
  );
endinterface

// File: rtl/lane_result_collector.sv
// lane_result_collector: captures a packed word of {carry, value} lane fields,
// ripples the lane carries one lane per clock, then presents the rebuilt
// LANES*LW-bit word with its final carry and error flag.
// Optional feature: define COLLECT_PARITY_EN to build per-byte even parity on
// out_par; otherwise out_par is tied to zero.
module lane_result_collector #(
  parameter int unsigned LANES = 8,
  parameter int unsigned LW    = 4
) (
  input logic                    clk,
  input logic                    rst,
  lane_result_collector_if.slave bus
);

  localparam int unsigned FW = LW + 1;
  localparam int unsigned DW = LANES * LW;
  localparam int unsigned IW = $clog2(LANES + 1);
  // Index value LANES is an extra RESOLVE cycle that commits the finished
  // word, so out_data moves only on the RESOLVE->DONE edge.
  localparam logic [IW-1:0] COMMIT = IW'(LANES);

  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LANES*FW-1:0] word_q;
  logic                err_q;
  logic [IW-1:0]       idx;
  logic [1:0]          carry;
  logic [DW-1:0]       work;
  logic [FW-1:0]       field;
  logic [LW+1:0]       acc;
  logic                accept;
  logic                commit;
  logic [DW-1:0]       data_q;
  logic                cay_q;
  logic                errout_q;

  assign accept = (state == IDLE) && bus.in_valid;
  assign commit = (state == RESOLVE) && (idx == COMMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RESOLVE;
      RESOLVE: if (idx == COMMIT) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Select the current lane field and add the running carry (max 2)
  always_comb begin
    field = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (idx == i[IW-1:0]) field = word_q[i*FW +: FW];
    end
    acc = {1'b0, field} + {{LW{1'b0}}, carry};
  end

  // Capture, per-lane ripple and final commit of the result word
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '0;
      err_q    <= 1'b0;
      idx      <= '0;
      carry    <= '0;
      work     <= '0;
      data_q   <= '0;
      cay_q    <= 1'b0;
      errout_q <= 1'b0;
    end else if (accept) begin
      word_q <= bus.in_data;
      err_q  <= bus.in_err;
      idx    <= '0;
      carry  <= '0;
      work   <= '0;
    end else if (state == RESOLVE) begin
      if (idx != COMMIT) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (idx == i[IW-1:0]) work[i*LW +: LW] <= acc[LW-1:0];
        end
        carry <= acc[LW+1:LW];
        idx   <= idx + 1'b1;
      end else begin
        data_q   <= work;
        cay_q    <= |carry;
        errout_q <= err_q;
      end
    end
  end

  assign bus.out_data = data_q;
  assign bus.out_cay  = cay_q;
  assign bus.out_err  = errout_q;

`ifdef COLLECT_PARITY_EN
  logic [DW/8-1:0] par_nxt;
  logic [DW/8-1:0] par_q;

  // Even parity of each byte of the word about to be committed
  always_comb begin
    par_nxt = '0;
    for (int unsigned k = 0; k < DW/8; k++) begin
      par_nxt[k] = ^work[k*8 +: 8];
    end
  end

  // Parity register updates together with out_data
  always_ff @(posedge clk) begin
    if (rst)         par_q <= '0;
    else if (commit) par_q <= par_nxt;
  end

  assign bus.out_par = par_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign bus.out_par   = '0;
`endif

endmodule
